proc_mem_queue: RTL and testbench
=================================

# proc_mem_queue

Parametrised, age-ordered transaction tracker for the AXI write path: records every accepted AW transaction (ID plus 2-bit type) in a compacting slot queue, and retires the oldest matching entry on each B handshake. Completions of BLOCK and DIVERT transactions are counted and exposed as level notifications (`block_fin`, `spec_release`) that the control logic drains one at a time with `block_ack` and `release_ready`. This block generalises the fixed 32-slot, 4-bit-ID process memory: it adds configurable depth and ID width, backpressure on AW, same-ID ordering, queued notifications, occupancy reporting and an unknown-BID error.

## Interface
- `SLOT_AMOUNT`, 32: number of slots (≥2).
- `ID_WIDTH`, 4: width of `awid`/`bid`.
- `AFULL_TH`, 28: `almost_full` threshold (1..SLOT_AMOUNT).
- `CW`, derived = $clog2(SLOT_AMOUNT+1): width of counters and occupancy.
- `clk` in 1: the single clock.
- `rst` in 1: asynchronous, active-high reset.
- `awid` in ID_WIDTH: AW transaction ID.
- `awvalid` in 1: AW valid.
- `awuser` in 2: transaction type. REGULAR=00, BLOCK=01, DIVERT=10, UNLUCKY=11.
- `awready` out 1: slot available. Equals `!full`.
- `bid` in ID_WIDTH: B response ID.
- `bvalid` in 1: B valid (monitored).
- `bready` in 1: B ready (monitored).
- `block_fin` out 1: one or more BLOCK completions are pending.
- `block_ack` in 1: consumes one BLOCK completion.
- `spec_release` out 1: one or more DIVERT completions are pending.
- `release_ready` in 1: consumes one DIVERT completion.
- `unlucky_done` out 1: one-cycle pulse when an UNLUCKY entry retires.
- `err_bid` out 1: one-cycle pulse when a B handshake matches no entry.
- `full` out 1: occupancy equals SLOT_AMOUNT.
- `almost_full` out 1: occupancy ≥ AFULL_TH.
- `occupancy` out CW: number of valid entries.

## Operation
**Storage**
- The store is an array of {id, type}, with valid entries packed at indices 0..occupancy-1.
- Index 0 always holds the oldest entry.

**Allocation**
- Occurs when `awvalid && awready`.
- The entry {awid, awuser} is written at index `occupancy` (after any deletion shift in the same cycle).

**Deletion**
- Occurs when `bvalid && bready`.
- The block finds the lowest index i with `id[i]==bid`, i.e. the oldest same-ID entry.
- Entries i+1..occupancy-1 shift down by one and occupancy decrements.
- Its type determines the side effect:
  - BLOCK: `blk_cnt` += 1.
  - DIVERT: `div_cnt` += 1.
  - UNLUCKY: pulse `unlucky_done`.
  - REGULAR: none.
- If no entry matches: pulse `err_bid`; the store is unchanged.

**Simultaneous allocation and deletion**
- The deletion is applied first, then the allocation is appended at `occupancy-1`.
- Net occupancy is unchanged.
- The entry being allocated is never a match candidate for the same-cycle `bid`, even if the IDs are equal.

**Notifications**
- `block_fin = (blk_cnt != 0)` and `spec_release = (div_cnt != 0)`.
- `block_ack` while `block_fin` is high decrements `blk_cnt`; `release_ready` while `spec_release` is high decrements `div_cnt`.
- An ack or release while the respective flag is low is ignored.
- Increment and decrement in the same cycle leave the counter unchanged.
- Both counters saturate at 2^CW-1; further increments are dropped.

**Backpressure and reset**
- Allocation while full is impossible, since `awready` is low.
- `awvalid` held high while `awready` is low produces no state change.
- Reset, including mid-operation, clears all entries and counters immediately.

## Timing
- All state updates occur on the rising edge of `clk`.
- `full`, `almost_full`, `occupancy`, `block_fin` and `spec_release` are registered-state functions and update one cycle after the causing handshake.
- `awready` is combinational from `full` only, with no path from `bvalid`. A slot freed by a B handshake is offered to AW the next cycle.
- `unlucky_done` and `err_bid` are registered and high exactly one cycle, in the cycle after the handshake.
- Reset values:
  - `awready`=1.
  - `full`, `almost_full`, `block_fin`, `spec_release`, `unlucky_done` and `err_bid` are 0.
  - `occupancy`=0.
- Throughput: one allocation and one deletion per cycle, sustained.

## Test plan
- **Allocate and delete:** reset, allocate (1,REGULAR), (2,DIVERT), then B with bid=1 → occupancy 1→2→1; index 0 then holds id 2; `spec_release` stays 0.
- **Same-ID ordering:** allocate (5,BLOCK), (5,REGULAR), then B with bid=5 → `block_fin`=1 one cycle later and occupancy=1. A second B with bid=5 → `block_fin` stays 1 (count 1), with no second increment. `block_ack` → `block_fin`=0 the next cycle.
- **Fill and backpressure (SLOT_AMOUNT=32, AFULL_TH=28):**
  - Allocate 32 REGULAR entries → `almost_full` after the 28th, `full` and `awready`=0 after the 32nd.
  - A 33rd `awvalid` held 3 cycles → occupancy stays 32.
  - One B handshake → `awready`=1 on the next cycle.
- **Simultaneous events:** at occupancy 4, same-cycle AW (9,UNLUCKY) and B bid=index-1 id → occupancy stays 4 and the new entry sits at index 3. A subsequent B with bid=9 → `unlucky_done` pulses for one cycle.
- **Queued notifications:** retire 3 DIVERT entries back-to-back, then hold `release_ready`=1 → `spec_release` stays high for exactly 3 cycles of `release_ready`. A B with unknown bid=15 → `err_bid` pulses once and occupancy is unchanged.
- **Reset mid-operation:** assert `rst` with occupancy 6 and `blk_cnt` 2 → all outputs return to reset values without waiting for a clock edge.

Source files
------------

// File: rtl/proc_mem_queue.sv
`default_nettype none
// ============================================================================
// Module  : proc_mem_queue
// Brief   : Age-ordered AXI write transaction tracker with compacting slots
//           and queued BLOCK/DIVERT completion notifications.
// Revision: 1.0 - initial release
// ============================================================================
module proc_mem_queue #(
  parameter int SLOT_AMOUNT = 32,
  parameter int ID_WIDTH    = 4,
  parameter int AFULL_TH    = 28,
  localparam int CW         = $clog2(SLOT_AMOUNT + 1)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [ID_WIDTH-1:0] awid,
  input  logic                awvalid,
  input  logic [1:0]          awuser,
  output logic                awready,
  input  logic [ID_WIDTH-1:0] bid,
  input  logic                bvalid,
  input  logic                bready,
  output logic                block_fin,
  input  logic                block_ack,
  output logic                spec_release,
  input  logic                release_ready,
  output logic                unlucky_done,
  output logic                err_bid,
  output logic                full,
  output logic                almost_full,
  output logic [CW-1:0]       occupancy
);

  localparam logic [1:0]    TYPE_BLOCK   = 2'b01;
  localparam logic [1:0]    TYPE_DIVERT  = 2'b10;
  localparam logic [1:0]    TYPE_UNLUCKY = 2'b11;
  localparam logic [CW-1:0] CNT_MAX      = {CW{1'b1}};
  localparam logic [CW-1:0] SLOTS        = CW'(SLOT_AMOUNT);
  localparam logic [CW-1:0] AFULL        = CW'(AFULL_TH);

  logic [ID_WIDTH-1:0] id_q   [SLOT_AMOUNT];
  logic [ID_WIDTH-1:0] id_d   [SLOT_AMOUNT];
  logic [1:0]          type_q [SLOT_AMOUNT];
  logic [1:0]          type_d [SLOT_AMOUNT];
  logic [CW-1:0]       occupancy_q, occupancy_d;
  logic [CW-1:0]       blk_cnt_q, blk_cnt_d;
  logic [CW-1:0]       div_cnt_q, div_cnt_d;
  logic                unlucky_q, unlucky_d;
  logic                err_q, err_d;

  logic          hit, del, alloc, blk_inc, blk_dec, div_inc, div_dec;
  logic [CW-1:0] hit_idx, occ_after;
  logic [1:0]    hit_type;

  assign full         = (occupancy_q == SLOTS);
  assign almost_full  = (occupancy_q >= AFULL);
  assign awready      = !full;
  assign occupancy    = occupancy_q;
  assign block_fin    = (blk_cnt_q != '0);
  assign spec_release = (div_cnt_q != '0);
  assign unlucky_done = unlucky_q;
  assign err_bid      = err_q;

  always_comb begin
    id_d      = id_q;
    type_d    = type_q;
    hit       = 1'b0;
    hit_idx   = '0;
    hit_type  = 2'b00;
    // Oldest live entry with a matching ID wins; the same-cycle AW entry is
    // not in the store yet, so it can never match.
    for (int i = 0; i < SLOT_AMOUNT; i++) begin
      if (!hit && (CW'(i) < occupancy_q) && (id_q[i] == bid)) begin
        hit      = 1'b1;
        hit_idx  = CW'(i);
        hit_type = type_q[i];
      end
    end
    del       = bvalid && bready && hit;
    alloc     = awvalid && awready;
    err_d     = bvalid && bready && !hit;
    unlucky_d = del && (hit_type == TYPE_UNLUCKY);

    if (del) begin
      for (int i = 0; i < SLOT_AMOUNT - 1; i++) begin
        if (CW'(i) >= hit_idx) begin
          id_d[i]   = id_q[i+1];
          type_d[i] = type_q[i+1];
        end
      end
    end
    occ_after = occupancy_q - {{(CW-1){1'b0}}, del};
    if (alloc) begin
      for (int i = 0; i < SLOT_AMOUNT; i++) begin
        if (CW'(i) == occ_after) begin
          id_d[i]   = awid;
          type_d[i] = awuser;
        end
      end
    end
    occupancy_d = occ_after + {{(CW-1){1'b0}}, alloc};

    blk_inc   = del && (hit_type == TYPE_BLOCK);
    blk_dec   = block_ack && (blk_cnt_q != '0);
    blk_cnt_d = blk_cnt_q;
    if (blk_inc && !blk_dec && (blk_cnt_q != CNT_MAX)) blk_cnt_d = blk_cnt_q + 1'b1;
    else if (blk_dec && !blk_inc)                      blk_cnt_d = blk_cnt_q - 1'b1;

    div_inc   = del && (hit_type == TYPE_DIVERT);
    div_dec   = release_ready && (div_cnt_q != '0);
    div_cnt_d = div_cnt_q;
    if (div_inc && !div_dec && (div_cnt_q != CNT_MAX)) div_cnt_d = div_cnt_q + 1'b1;
    else if (div_dec && !div_inc)                      div_cnt_d = div_cnt_q - 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < SLOT_AMOUNT; i++) begin
        id_q[i]   <= '0;
        type_q[i] <= '0;
      end
      occupancy_q <= '0;
      blk_cnt_q   <= '0;
      div_cnt_q   <= '0;
      unlucky_q   <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      id_q        <= id_d;
      type_q      <= type_d;
      occupancy_q <= occupancy_d;
      blk_cnt_q   <= blk_cnt_d;
      div_cnt_q   <= div_cnt_d;
      unlucky_q   <= unlucky_d;
      err_q       <= err_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_proc_mem_queue.sv
`default_nettype none
// ============================================================================
// Module  : tb_proc_mem_queue
// Brief   : Scoreboard bench for proc_mem_queue against a queue-based model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_proc_mem_queue;

  localparam int SLOTS = 32;
  localparam int AFTH  = 28;
  localparam int CMAX  = 63;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] awid = '0, bid = '0;
  logic       awvalid = 1'b0, bvalid = 1'b0, bready = 1'b0;
  logic [1:0] awuser = '0;
  logic       block_ack = 1'b0, release_ready = 1'b0;
  logic       awready, block_fin, spec_release, unlucky_done, err_bid;
  logic       full, almost_full;
  logic [5:0] occupancy;

  proc_mem_queue #(.SLOT_AMOUNT(SLOTS), .ID_WIDTH(4), .AFULL_TH(AFTH)) dut (
    .clk(clk), .rst(rst), .awid(awid), .awvalid(awvalid), .awuser(awuser),
    .awready(awready), .bid(bid), .bvalid(bvalid), .bready(bready),
    .block_fin(block_fin), .block_ack(block_ack), .spec_release(spec_release),
    .release_ready(release_ready), .unlucky_done(unlucky_done), .err_bid(err_bid),
    .full(full), .almost_full(almost_full), .occupancy(occupancy)
  );

  always #5 clk = ~clk;

  typedef struct { logic [3:0] id; logic [1:0] t; } entry_t;
  typedef logic [12:0] obs_t; // {awready, full, afull, blk_fin, spec_rel, unl, err, occ[5:0]}

  entry_t mq[$];
  int     m_blk = 0, m_div = 0;
  obs_t   exp_q[$];
  int     n_checks = 0, n_err = 0;
  int     cyc = 0;

  function automatic obs_t pack_dut();
    return {awready, full, almost_full, block_fin, spec_release, unlucky_done, err_bid, occupancy};
  endfunction

  // Applies one cycle of inputs and records what the outputs must be after the edge.
  task automatic cycle(input logic av, input logic [3:0] aid, input logic [1:0] au,
                       input logic bv, input logic br, input logic [3:0] b_id,
                       input logic back, input logic rr);
    int   found;
    logic unl, err, binc, dinc, bdec, ddec;
    int   occ;
    @(negedge clk);
    awvalid = av; awid = aid; awuser = au;
    bvalid = bv; bready = br; bid = b_id;
    block_ack = back; release_ready = rr;
    unl = 0; err = 0; binc = 0; dinc = 0;
    bdec = back && (m_blk > 0);
    ddec = rr && (m_div > 0);
    occ = mq.size();
    if (bv && br) begin
      found = -1;
      for (int i = 0; i < mq.size(); i++)
        if (found < 0 && mq[i].id == b_id) found = i;
      if (found < 0) err = 1;
      else begin
        case (mq[found].t)
          2'b01: binc = 1;
          2'b10: dinc = 1;
          2'b11: unl = 1;
          default: ;
        endcase
        mq.delete(found);
      end
    end
    if (av && occ < SLOTS) mq.push_back('{id: aid, t: au});
    if (binc && !bdec) begin if (m_blk < CMAX) m_blk++; end
    else if (bdec && !binc) m_blk--;
    if (dinc && !ddec) begin if (m_div < CMAX) m_div++; end
    else if (ddec && !dinc) m_div--;
    occ = mq.size();
    exp_q.push_back({occ != SLOTS, occ == SLOTS, occ >= AFTH, m_blk != 0, m_div != 0,
                     unl, err, 6'(occ)});
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    obs_t act;
    act = pack_dut();
    n_checks++;
    if (act !== 13'b1_0_0_0_0_0_0_000000) begin
      n_err++;
      $display("FAIL %s reset outputs: got %b required %b", tag, act, 13'b1_0_0_0_0_0_0_000000);
    end
  endtask

  // Monitor: every post-edge observation consumes one expectation.
  initial begin
    obs_t e, a;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (!rst && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        a = pack_dut();
        n_checks++;
        if (a !== e) begin
          n_err++;
          $display("FAIL cycle %0d outputs {awr,full,af,bfin,srel,unl,err,occ}: got %b required %b",
                   cyc, a, e);
        end
      end
    end
  end

  initial begin
    #1;
    check_reset_outputs("initial");
    #20;
    @(negedge clk);
    rst = 1'b0;

    // Allocate and delete
    cycle(1, 1, 2'b00, 0, 0, 0, 0, 0);
    cycle(1, 2, 2'b10, 0, 0, 0, 0, 0);
    cycle(0, 0, 0, 1, 1, 1, 0, 0);
    cycle(0, 0, 0, 1, 1, 2, 0, 0);   // id 2 now at index 0 must still match
    cycle(0, 0, 0, 0, 0, 0, 0, 1);
    // Same-ID ordering
    cycle(1, 5, 2'b01, 0, 0, 0, 0, 0);
    cycle(1, 5, 2'b00, 0, 0, 0, 0, 0);
    cycle(0, 0, 0, 1, 1, 5, 0, 0);
    cycle(0, 0, 0, 1, 1, 5, 0, 0);
    cycle(0, 0, 0, 0, 0, 0, 1, 0);
    idle(1);
    // Fill and backpressure
    for (int i = 0; i < SLOTS; i++) cycle(1, 4'(i % 16), 2'b00, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) cycle(1, 4'hE, 2'b01, 0, 0, 0, 0, 0);
    cycle(0, 0, 0, 1, 1, 7, 0, 0);
    cycle(1, 4'hE, 2'b11, 0, 0, 0, 0, 0);
    while (mq.size() > 0) cycle(0, 0, 0, 1, 1, mq[0].id, 0, 0);
    // Simultaneous events at occupancy 4
    for (int i = 0; i < 4; i++) cycle(1, 4'(i + 1), 2'b00, 0, 0, 0, 0, 0);
    cycle(1, 9, 2'b11, 1, 1, mq[1].id, 0, 0);
    cycle(0, 0, 0, 1, 1, 9, 0, 0);
    idle(1);
    // Same-cycle allocation with an ID equal to bid must not self-match
    cycle(1, 4'hC, 2'b01, 1, 1, 4'hC, 0, 0);
    // Queued notifications
    for (int i = 0; i < 3; i++) cycle(1, 4'hA, 2'b10, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) cycle(0, 0, 0, 1, 1, 4'hA, 0, 0);
    for (int i = 0; i < 5; i++) cycle(0, 0, 0, 0, 0, 0, 0, 1);
    cycle(0, 0, 0, 1, 1, 4'hF, 0, 0);
    idle(1);
    // Random traffic, biased first towards filling, then balanced
    for (int n = 0; n < 3000; n++) begin
      logic       av, bv, br, back, rr;
      logic [3:0] aid, b_id;
      av   = $urandom_range(0, 99) < (n < 1000 ? 85 : 55);
      bv   = $urandom_range(0, 99) < (n < 1000 ? 35 : 55);
      br   = $urandom_range(0, 99) < 85;
      aid  = 4'($urandom_range(0, 7));
      b_id = (mq.size() > 0 && $urandom_range(0, 99) < 85) ?
             mq[$urandom_range(0, mq.size() - 1)].id : 4'($urandom_range(0, 15));
      back = $urandom_range(0, 99) < 25;
      rr   = $urandom_range(0, 99) < 25;
      cycle(av, aid, 2'($urandom_range(0, 3)), bv, br, b_id, back, rr);
    end
    // Drain, then build occupancy 6 with two pending BLOCK completions
    while (mq.size() > 0) cycle(0, 0, 0, 1, 1, mq[0].id, 1, 1);
    idle(70);
    cycle(1, 3, 2'b01, 0, 0, 0, 0, 0);
    cycle(1, 4, 2'b01, 0, 0, 0, 0, 0);
    cycle(0, 0, 0, 1, 1, 3, 0, 0);
    cycle(0, 0, 0, 1, 1, 4, 0, 0);
    for (int i = 0; i < 6; i++) cycle(1, 4'(i), 2'b00, 0, 0, 0, 0, 0);
    idle(1);
    // Asynchronous reset between edges
    @(negedge clk);
    awvalid = 0; bvalid = 0; bready = 0; block_ack = 0; release_ready = 0;
    #2;
    rst = 1'b1;
    #1;
    check_reset_outputs("mid-operation");
    mq.delete();
    m_blk = 0; m_div = 0;
    @(negedge clk);
    rst = 1'b0;
    cycle(1, 6, 2'b00, 0, 0, 0, 0, 0);
    cycle(0, 0, 0, 1, 1, 6, 0, 0);
    idle(1);
    @(negedge clk);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL scoreboard drain: got %0d pending required 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
